// File: rtl/xgmii_rs_fault_handler.sv
// XGMII reconciliation-sublayer link fault handler.
// Watches the receive XGMII stream for local/remote fault ordered sets,
// declares a link fault after four same-type sequence words, clears it after
// a run of non-sequence words, and overrides the transmit stream so the MAC
// side reacts (remote fault towards a local fault, idle towards a remote one).
module xgmii_rs_fault_handler #(
   parameter int DATA_WIDTH  = 64,
   parameter int CTRL_WIDTH  = DATA_WIDTH/8,
   parameter int CLEAR_WORDS = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] rx_xgmii_rxd,
   input  logic [CTRL_WIDTH-1:0] rx_xgmii_rxc,
   input  logic                  rx_block_lock,
   input  logic [DATA_WIDTH-1:0] tx_xgmii_txd_in,
   input  logic [CTRL_WIDTH-1:0] tx_xgmii_txc_in,
   output logic [DATA_WIDTH-1:0] tx_xgmii_txd_out,
   output logic [CTRL_WIDTH-1:0] tx_xgmii_txc_out,
   output logic [1:0]            status_link_fault,
   output logic [15:0]           status_fault_count
);

   // Sequence / link status encoding: none-or-OK, local fault, remote fault.
   localparam logic [1:0] SEQ_NONE   = 2'b00;
   localparam logic [1:0] SEQ_LOCAL  = 2'b01;
   localparam logic [1:0] SEQ_REMOTE = 2'b10;

   // Column counter is sized so that its top value marks the last word of
   // the clearing run.
   localparam int              COL_W    = (CLEAR_WORDS > 1) ? $clog2(CLEAR_WORDS) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(CLEAR_WORDS - 1);

   // Transmit override patterns, replicated across the bus.
   localparam logic [DATA_WIDTH-1:0] TXD_IDLE = {(DATA_WIDTH/8){8'h07}};
   localparam logic [CTRL_WIDTH-1:0] TXC_IDLE = {CTRL_WIDTH{1'b1}};
   localparam logic [DATA_WIDTH-1:0] TXD_RF   = {(DATA_WIDTH/32){32'h0200009C}};
   localparam logic [CTRL_WIDTH-1:0] TXC_RF   = {(CTRL_WIDTH/4){4'h1}};

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_COUNT = 2'd1,
      ST_FAULT = 2'd2
   } state_e;

   state_e                  state_q, state_d;
   logic [1:0]              last_type_q, last_type_d;
   logic [1:0]              fault_cnt_q, fault_cnt_d;
   logic [COL_W-1:0]        col_cnt_q, col_cnt_d;
   logic [1:0]              link_fault_int_q, link_fault_int_d;
   logic [1:0]              status_q, status_d;
   logic [15:0]             fault_count_q, fault_count_d;
   logic [DATA_WIDTH-1:0]   txd_q, txd_d;
   logic [CTRL_WIDTH-1:0]   txc_q, txc_d;

   logic [1:0][1:0]         lane_type;
   logic [1:0]              rx_type;

   // Decode a fault sequence column in lane 0 and lane 4: control 0x9C
   // followed by three data lanes 00, 00, type; only types 01/02 count.
   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      localparam int B = gi * 32;
      localparam int C = gi * 4;
      logic is_seq_col;
      logic type_ok;
      assign is_seq_col = rx_xgmii_rxc[C] && (rx_xgmii_rxc[C+3:C+1] == 3'b000)
                          && (rx_xgmii_rxd[B +: 8] == 8'h9C)
                          && (rx_xgmii_rxd[B+8 +: 16] == 16'h0000);
      assign type_ok    = (rx_xgmii_rxd[B+24 +: 8] == 8'h01) ||
                          (rx_xgmii_rxd[B+24 +: 8] == 8'h02);
      assign lane_type[gi] = (is_seq_col && type_ok) ? rx_xgmii_rxd[B+24 +: 2] : SEQ_NONE;
   end

   // Lane 4 wins when both columns carry a sequence.
   assign rx_type = (lane_type[1] != SEQ_NONE) ? lane_type[1] : lane_type[0];

   // Fault state machine next-state, plus status and entry counter.
   always_comb begin
      logic go_init;
      state_d          = state_q;
      last_type_d      = last_type_q;
      fault_cnt_d      = fault_cnt_q;
      col_cnt_d        = col_cnt_q;
      link_fault_int_d = link_fault_int_q;
      go_init          = 1'b0;

      if (!rx_block_lock) begin
         go_init = 1'b1;
      end else begin
         case (state_q)
            ST_INIT: begin
               if (rx_type != SEQ_NONE) begin
                  state_d     = ST_COUNT;
                  last_type_d = rx_type;
                  fault_cnt_d = 2'd1;
                  col_cnt_d   = '0;
               end
            end
            ST_COUNT: begin
               if (rx_type == SEQ_NONE) begin
                  if (col_cnt_q == COL_LAST) go_init = 1'b1;
                  else                       col_cnt_d = col_cnt_q + 1'b1;
               end else if (rx_type == last_type_q) begin
                  col_cnt_d = '0;
                  if (fault_cnt_q == 2'd3) begin
                     state_d          = ST_FAULT;
                     link_fault_int_d = rx_type;
                  end else begin
                     fault_cnt_d = fault_cnt_q + 2'd1;
                  end
               end else begin
                  last_type_d = rx_type;
                  fault_cnt_d = 2'd1;
                  col_cnt_d   = '0;
               end
            end
            ST_FAULT: begin
               if (rx_type == SEQ_NONE) begin
                  if (col_cnt_q == COL_LAST) go_init = 1'b1;
                  else                       col_cnt_d = col_cnt_q + 1'b1;
               end else if (rx_type == link_fault_int_q) begin
                  col_cnt_d = '0;
               end else begin
                  // Fault indication is kept while the new type is counted.
                  state_d     = ST_COUNT;
                  last_type_d = rx_type;
                  fault_cnt_d = 2'd1;
                  col_cnt_d   = '0;
               end
            end
            default: go_init = 1'b1;
         endcase
      end

      if (go_init) begin
         state_d          = ST_INIT;
         last_type_d      = SEQ_NONE;
         fault_cnt_d      = 2'd0;
         col_cnt_d        = '0;
         link_fault_int_d = SEQ_NONE;
      end

      // Loss of block lock is reported as a local fault.
      status_d      = rx_block_lock ? link_fault_int_d : SEQ_LOCAL;
      fault_count_d = fault_count_q;
      if ((status_q == SEQ_NONE) && (status_d != SEQ_NONE) && (fault_count_q != 16'hFFFF))
         fault_count_d = fault_count_q + 16'd1;
   end

   // Transmit override selected by the already-registered status.
   always_comb begin
      txd_d = TXD_IDLE;
      txc_d = TXC_IDLE;
      case (status_q)
         SEQ_NONE: begin
            txd_d = tx_xgmii_txd_in;
            txc_d = tx_xgmii_txc_in;
         end
         SEQ_LOCAL: begin
            txd_d = TXD_RF;
            txc_d = TXC_RF;
         end
         default: begin
            txd_d = TXD_IDLE;
            txc_d = TXC_IDLE;
         end
      endcase
   end

   // State, status and transmit registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_INIT;
         last_type_q      <= SEQ_NONE;
         fault_cnt_q      <= 2'd0;
         col_cnt_q        <= '0;
         link_fault_int_q <= SEQ_NONE;
         status_q         <= SEQ_NONE;
         fault_count_q    <= 16'd0;
         txd_q            <= TXD_IDLE;
         txc_q            <= TXC_IDLE;
      end else begin
         state_q          <= state_d;
         last_type_q      <= last_type_d;
         fault_cnt_q      <= fault_cnt_d;
         col_cnt_q        <= col_cnt_d;
         link_fault_int_q <= link_fault_int_d;
         status_q         <= status_d;
         fault_count_q    <= fault_count_d;
         txd_q            <= txd_d;
         txc_q            <= txc_d;
      end
   end

   assign tx_xgmii_txd_out   = txd_q;
   assign tx_xgmii_txc_out   = txc_q;
   assign status_link_fault  = status_q;
   assign status_fault_count = fault_count_q;

endmodule

// File: tb/tb_xgmii_rs_fault_handler.sv
// Bench for xgmii_rs_fault_handler: a reference model predicts status, fault
// count and transmit words for every clock; predictions are queued when a word
// is driven and compared after the edge that registers it.
module tb_xgmii_rs_fault_handler;

   localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
   localparam logic [7:0]  IDLE_C  = 8'hFF;
   localparam logic [63:0] LF_D    = 64'h0100009C0100009C;
   localparam logic [7:0]  LF_C    = 8'h11;
   localparam logic [63:0] RF4_D   = 64'h0200009C00000000;
   localparam logic [7:0]  RF4_C   = 8'h10;
   localparam logic [63:0] RFSEQ_D = 64'h0200009C0200009C;
   localparam logic [7:0]  RFSEQ_C = 8'h11;
   localparam int          CLEAR   = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] rx_d = IDLE_D;
   logic [7:0]  rx_c = IDLE_C;
   logic        lock = 1'b1;
   logic [63:0] mac_d = IDLE_D;
   logic [7:0]  mac_c = IDLE_C;
   logic [63:0] txd_out;
   logic [7:0]  txc_out;
   logic [1:0]  status;
   logic [15:0] fcount;

   always #5 clk = ~clk;

   xgmii_rs_fault_handler #(
      .DATA_WIDTH (64),
      .CTRL_WIDTH (8),
      .CLEAR_WORDS(CLEAR)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .rx_xgmii_rxd      (rx_d),
      .rx_xgmii_rxc      (rx_c),
      .rx_block_lock     (lock),
      .tx_xgmii_txd_in   (mac_d),
      .tx_xgmii_txc_in   (mac_c),
      .tx_xgmii_txd_out  (txd_out),
      .tx_xgmii_txc_out  (txc_out),
      .status_link_fault (status),
      .status_fault_count(fcount)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct packed {
      logic [1:0]  st;
      logic [15:0] cnt;
      logic [63:0] txd;
      logic [7:0]  txc;
   } exp_t;
   exp_t sb_q[$];

   // Reference model: 0=INIT 1=COUNT 2=FAULT; types 0 none, 1 LF, 2 RF.
   int m_state, m_last, m_cnt, m_col, m_lfi, m_status, m_count;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
      end
   endtask

   function automatic int seq_type(input logic [63:0] d, input logic [7:0] c);
      int          t;
      logic [31:0] col;
      logic [3:0]  cc;
      t = 0;
      for (int l = 0; l < 2; l++) begin
         col = d[l*32 +: 32];
         cc  = c[l*4 +: 4];
         if (cc == 4'b0001 && col[7:0] == 8'h9C && col[23:8] == 16'h0 &&
             (col[31:24] == 8'h01 || col[31:24] == 8'h02))
            t = int'(col[31:24]);
      end
      return t;
   endfunction

   task automatic model_init();
      m_state = 0; m_cnt = 0; m_col = 0; m_lfi = 0; m_last = 0;
   endtask

   task automatic model_reset();
      model_init();
      m_status = 0;
      m_count  = 0;
   endtask

   task automatic model_update(input int t, input logic lk);
      int new_st;
      if (!lk) begin
         model_init();
      end else if (t == 0) begin
         if (m_state != 0) begin
            m_col++;
            if (m_col >= CLEAR) model_init();
         end
      end else if (m_state == 0) begin
         m_state = 1; m_last = t; m_cnt = 1; m_col = 0;
      end else if (m_state == 1) begin
         m_col = 0;
         if (t == m_last) begin
            if (m_cnt == 3) begin m_state = 2; m_lfi = t; end
            else m_cnt++;
         end else begin
            m_last = t; m_cnt = 1;
         end
      end else begin
         m_col = 0;
         if (t != m_lfi) begin m_state = 1; m_last = t; m_cnt = 1; end
      end
      new_st = lk ? m_lfi : 1;
      if (m_status == 0 && new_st != 0 && m_count < 65535) m_count++;
      m_status = new_st;
   endtask

   // Drive one word on every input, predict, clock, compare.
   task automatic step(input logic [63:0] d, input logic [7:0] c, input logic lk,
                       input logic [63:0] md, input logic [7:0] mc);
      exp_t e;
      int   old_st;
      rx_d = d; rx_c = c; lock = lk; mac_d = md; mac_c = mc;
      old_st = m_status;
      if (rst) begin
         model_reset();
         e.txd = IDLE_D;
         e.txc = IDLE_C;
      end else begin
         model_update(seq_type(d, c), lk);
         case (old_st)
            0:       begin e.txd = md;      e.txc = mc;      end
            1:       begin e.txd = RFSEQ_D; e.txc = RFSEQ_C; end
            default: begin e.txd = IDLE_D;  e.txc = IDLE_C;  end
         endcase
      end
      e.st  = 2'(m_status);
      e.cnt = 16'(m_count);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      e = sb_q.pop_front();
      check("status", 64'(status), 64'(e.st));
      check("count", 64'(fcount), 64'(e.cnt));
      check("txd", txd_out, e.txd);
      check("txc", 64'(txc_out), 64'(e.txc));
      $display("cyc %0d rxd=%h rxc=%h lock=%b mac=%h/%h -> st=%b cnt=%0d tx=%h/%h",
               cyc, d, c, lk, md, mc, status, fcount, txd_out, txc_out);
   endtask

   task automatic mac_rand(output logic [63:0] md, output logic [7:0] mc);
      md = {$urandom, $urandom};
      mc = 8'($urandom_range(0, 255));
   endtask

   task automatic rx_word(input logic [63:0] d, input logic [7:0] c);
      logic [63:0] md;
      logic [7:0]  mc;
      mac_rand(md, mc);
      step(d, c, 1'b1, md, mc);
   endtask

   task automatic rx_rand(output logic [63:0] d, output logic [7:0] c);
      case ($urandom_range(0, 7))
         0, 1:    begin d = LF_D;                  c = LF_C;  end
         2:       begin d = RF4_D;                 c = RF4_C; end
         3:       begin d = 64'h070707070200009C;  c = 8'hF1; end   // RF in lane 0
         4:       begin d = 64'h0200009C0100009C;  c = 8'h11; end   // lane 4 RF wins
         5:       begin d = 64'h0300009C0300009C;  c = 8'h11; end   // type 03: not a sequence
         6:       begin d = {$urandom, $urandom};  c = 8'h00; end
         default: begin d = IDLE_D;                c = IDLE_C; end
      endcase
   endtask

   initial begin
      logic [63:0] md, d;
      logic [7:0]  mc, c;
      model_reset();

      // Reset held with lock up and MAC idle.
      for (int i = 0; i < 3; i++) step(IDLE_D, IDLE_C, 1'b1, IDLE_D, IDLE_C);
      check("rst_txd", txd_out, IDLE_D);
      check("rst_txc", 64'(txc_out), 64'(IDLE_C));
      check("rst_status", 64'(status), 64'd0);
      check("rst_count", 64'(fcount), 64'd0);
      rst = 1'b0;

      // Pass-through of MAC words.
      for (int i = 0; i < 4; i++) rx_word(IDLE_D, IDLE_C);

      // Four LF words declare a local fault.
      for (int i = 0; i < 4; i++) rx_word(LF_D, LF_C);
      check("lf_status", 64'(status), 64'd1);
      check("lf_count", 64'(fcount), 64'd1);

      // Local fault clears on the 64th non-sequence word.
      for (int i = 0; i < CLEAR; i++) begin
         rx_word(IDLE_D, IDLE_C);
         if (i == 0)         check("lf_txd", txd_out, RFSEQ_D);
         if (i == CLEAR - 2) check("lf_hold", 64'(status), 64'd1);
         if (i == CLEAR - 1) check("lf_clear", 64'(status), 64'd0);
      end
      mac_rand(md, mc);
      step(IDLE_D, IDLE_C, 1'b1, md, mc);
      check("pass_resume", txd_out, md);

      // Three LF, expiry, then one LF leaves COUNT with one sequence seen.
      for (int i = 0; i < 3; i++) rx_word(LF_D, LF_C);
      for (int i = 0; i < CLEAR; i++) rx_word(IDLE_D, IDLE_C);
      rx_word(LF_D, LF_C);
      check("expire_status", 64'(status), 64'd0);
      for (int i = 0; i < 2; i++) rx_word(LF_D, LF_C);
      check("cnt3_status", 64'(status), 64'd0);
      rx_word(LF_D, LF_C);
      check("cnt4_status", 64'(status), 64'd1);
      check("cnt4_count", 64'(fcount), 64'd2);
      for (int i = 0; i < CLEAR; i++) rx_word(IDLE_D, IDLE_C);

      // Remote fault from lane-4 sequences, then LF does not change status.
      for (int i = 0; i < 4; i++) rx_word(RF4_D, RF4_C);
      check("rf_status", 64'(status), 64'd2);
      check("rf_count", 64'(fcount), 64'd3);
      rx_word(IDLE_D, IDLE_C);
      check("rf_txd", txd_out, IDLE_D);
      rx_word(LF_D, LF_C);
      check("rf_lf_hold", 64'(status), 64'd2);
      for (int i = 0; i < 3; i++) rx_word(LF_D, LF_C);
      check("rf_to_lf", 64'(status), 64'd1);
      check("rf_to_lf_cnt", 64'(fcount), 64'd3);
      for (int i = 0; i < CLEAR; i++) rx_word(IDLE_D, IDLE_C);
      check("rf_lf_clear", 64'(status), 64'd0);

      // One-cycle loss of block lock.
      mac_rand(md, mc);
      step(IDLE_D, IDLE_C, 1'b0, md, mc);
      check("nolock_status", 64'(status), 64'd1);
      check("nolock_count", 64'(fcount), 64'd4);
      rx_word(IDLE_D, IDLE_C);
      check("relock_status", 64'(status), 64'd0);

      // Asynchronous reset mid-fault abandons all progress.
      for (int i = 0; i < 4; i++) rx_word(LF_D, LF_C);
      rx_word(IDLE_D, IDLE_C);
      #2;
      rst = 1'b1;
      #1;
      check("arst_status", 64'(status), 64'd0);
      check("arst_count", 64'(fcount), 64'd0);
      check("arst_txd", txd_out, IDLE_D);
      check("arst_txc", 64'(txc_out), 64'(IDLE_C));
      model_reset();
      step(LF_D, LF_C, 1'b1, IDLE_D, IDLE_C);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) rx_word(LF_D, LF_C);
      check("arst_3lf", 64'(status), 64'd0);
      rx_word(LF_D, LF_C);
      check("arst_4lf", 64'(status), 64'd1);
      check("arst_4lf_cnt", 64'(fcount), 64'd1);

      // Random mix of sequence, idle, data and lock loss.
      for (int i = 0; i < 400; i++) begin
         rx_rand(d, c);
         mac_rand(md, mc);
         step(d, c, ($urandom_range(0, 99) >= 3), md, mc);
         if ($urandom_range(0, 99) < 2)
            for (int k = 0; k < CLEAR; k++) rx_word(IDLE_D, IDLE_C);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
